fifo_word_unpacker: RTL and testbench
=====================================

Name: fifo_word_unpacker

Overview:
- Drains 32-bit words from a generic FIFO read port (valid/pop, skid-buffered) and emits them as an 8-bit byte stream with valid/ready/last.
- A transfer starts with a byte-length command. It runs until that many bytes are delivered downstream.
- Sits between the 256x32 FIFO read side and byte-oriented consumers (UART TX, SPI flash writer, JPEG bitstream feeder).

Parameters:
- LEN_W, 16, width of the byte-count command and the internal remaining counter.
- BIG_ENDIAN, 0, byte order within a word. 0: byte0 = bits[7:0]. 1: byte0 = bits[31:24].

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset
- flush_i  input  1  abort the current transfer and return to idle
- start_i  input  1  command strobe; sampled only in IDLE
- len_i  input  LEN_W  byte count for the command
- busy_o  output  1  high while not IDLE
- done_o  output  1  one-cycle pulse when the final byte is accepted
- fifo_data_i  input  32  FIFO read data; valid when fifo_valid_i
- fifo_valid_i  input  1  FIFO has a word at its head
- fifo_pop_o  output  1  consume the head word (only asserted with fifo_valid_i)
- byte_o  output  8  downstream byte
- byte_valid_o  output  1  downstream valid
- byte_ready_i  input  1  downstream ready
- byte_last_o  output  1  marks the final byte of the transfer

Behaviour:
- Interface: single clock clk_i. Reset rst_i is synchronous, active-high.
- Reset values: all outputs 0. State = IDLE, hold register = 0, byte index = 0, remaining = 0.
- Registered state: state, hold[31:0], idx[1:0], rem[LEN_W-1:0].
- FIFO side: a word transfers in any cycle with fifo_valid_i & fifo_pop_o. fifo_pop_o is combinational from state, idx, rem, fifo_valid_i and byte_ready_i. fifo_pop_o is never asserted while fifo_valid_i = 0.
- Downstream side: a byte transfers when byte_valid_o & byte_ready_i.
  - byte_valid_o = (state == DRAIN).
  - byte_o = hold byte selected by idx, according to BIG_ENDIAN.
  - byte_last_o = byte_valid_o & (rem == 1).
  - byte_o and byte_last_o stay stable while byte_valid_o & !byte_ready_i.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - start_i with len_i != 0: rem <= len_i, go to LOAD.
  - start_i with len_i == 0: stay IDLE and pulse done_o the next cycle.
  - start_i is ignored in every other state.
- LOAD:
  - fifo_pop_o = fifo_valid_i.
  - On a pop: hold <= fifo_data_i, idx <= 0, go to DRAIN.
  - Otherwise wait indefinitely.
- DRAIN, on each accepted byte: rem <= rem - 1, idx <= idx + 1 (wraps mod 4).
  - rem == 1 (last byte): go to IDLE and pulse done_o. Unused bytes of the current word are discarded; the word was already popped.
  - idx == 3 and rem > 1, fifo_valid_i = 1: pop in the same cycle, load hold, idx <= 0, stay in DRAIN. No bubble; the next byte is valid the following cycle.
  - idx == 3 and rem > 1, fifo_valid_i = 0: go to LOAD. byte_valid_o drops until a word arrives.
  - Otherwise stay in DRAIN.
- Throughput: one byte per cycle sustained when the FIFO is non-empty and the downstream is always ready.
- Latency: the first byte is valid 2 cycles after start_i when fifo_valid_i is already high (start -> LOAD -> DRAIN).
- Word count: a transfer of N bytes pops exactly ceil(N/4) words. It never pops a word beyond that.
- flush_i:
  - Highest priority below rst_i, in any state.
  - Next cycle: state = IDLE, rem = 0, idx = 0, hold = 0.
  - No done_o pulse, no pop in the flush cycle.
  - flush_i together with start_i: flush wins and the command is dropped.
- Counter width: len_i is treated as unsigned, so the maximum transfer is 2^LEN_W - 1 bytes. rem never underflows because IDLE is entered at rem == 1.
- busy_o = (state != IDLE). done_o is registered and high for exactly one cycle.

Test Plan:
1. Basic transfer: FIFO holds 0x44332211, 0x88776655. len=8, ready tied 1, BIG_ENDIAN=0 -> bytes 11,22,33,44,55,66,77,88 on consecutive cycles; last on 0x88; exactly 2 pops; done_o one cycle after the last byte.
2. Partial word: len=5, FIFO holds 0xDDCCBBAA, 0x000000EE, 0x12345678 -> bytes AA,BB,CC,DD,EE with last on EE; exactly 2 pops; 0x12345678 remains at the FIFO head.
3. Backpressure and starvation: ready toggles 1,0,0,1 and the FIFO empties after word 1 of len=8 -> byte_o stable during stalls; byte_valid_o low while in LOAD; order preserved; no pop while fifo_valid_i = 0.
4. Big-endian with zero length: BIG_ENDIAN=1, word 0xA1B2C3D4, len=4 -> bytes A1,B2,C3,D4. Then start with len=0 -> no pop, no byte_valid_o, done_o pulse, busy_o stays 0.
5. Flush mid-transfer: len=12, flush_i after byte 6 -> next cycle IDLE, byte_valid_o=0, no done_o. A new len=4 command then streams the next FIFO word correctly.
6. Reset mid-transfer: rst_i while in DRAIN with start_i held -> all outputs 0 next cycle; the command is ignored until rst_i falls.

Source files
------------

// File: rtl/fifo_word_unpacker.sv
// Unpacks 32-bit FIFO words into a length-bounded byte stream with valid/ready/last.
// A transfer pops exactly ceil(len/4) words and pulses done_o on the final accepted byte.
module fifo_word_unpacker #(
    parameter int unsigned LEN_W      = 16,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic [31:0]      fifo_data_i,
    input  logic             fifo_valid_i,
    output logic             fifo_pop_o,
    output logic [7:0]       byte_o,
    output logic             byte_valid_o,
    input  logic             byte_ready_i,
    output logic             byte_last_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic [1:0]       idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic [1:0]       sel;
    logic             rem_is_one;

    assign rem_is_one = (rem_q == LEN_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hold_q  <= 32'd0;
            idx_q   <= 2'd0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Next-state and FIFO pop; reset and flush both suppress any pop this cycle.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        fifo_pop_o = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            hold_d  = 32'd0;
            idx_d   = 2'd0;
            rem_d   = '0;
        end else if (!rst_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            rem_d   = len_i;
                            state_d = ST_LOAD;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    fifo_pop_o = fifo_valid_i;
                    if (fifo_valid_i) begin
                        hold_d  = fifo_data_i;
                        idx_d   = 2'd0;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (byte_ready_i) begin
                        rem_d = rem_q - LEN_W'(1);
                        idx_d = idx_q + 2'd1;
                        if (rem_is_one) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (idx_q == 2'd3) begin
                            // Word exhausted with bytes still owed: refill without a bubble if possible.
                            if (fifo_valid_i) begin
                                fifo_pop_o = 1'b1;
                                hold_d     = fifo_data_i;
                                idx_d      = 2'd0;
                            end else begin
                                state_d = ST_LOAD;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign sel = BIG_ENDIAN ? ~idx_q : idx_q;

    always_comb begin
        byte_o = 8'd0;
        unique case (sel)
            2'd0: byte_o = hold_q[7:0];
            2'd1: byte_o = hold_q[15:8];
            2'd2: byte_o = hold_q[23:16];
            2'd3: byte_o = hold_q[31:24];
            default: byte_o = 8'd0;
        endcase
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign byte_valid_o = (state_q == ST_DRAIN);
    assign byte_last_o  = byte_valid_o & rem_is_one;
    assign done_o       = done_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Scoreboard bench: little- and big-endian instances share all inputs and a queue-backed FIFO model.
module tb_fifo_word_unpacker;

    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      fifo_data;
    logic             fifo_valid;
    logic             ready;

    logic       o_busy  [2];
    logic       o_done  [2];
    logic       o_pop   [2];
    logic [7:0] o_byte  [2];
    logic       o_valid [2];
    logic       o_last  [2];

    logic [31:0] fifo_q[$];
    logic [8:0]  exp_le[$];
    logic [8:0]  exp_be[$];

    int total = 0;
    int bad   = 0;
    int n_pops = 0;
    int acc_cnt = 0;
    bit mon_en = 1'b0;
    bit exp_done_nx = 1'b0;
    bit         prv_stall [2];
    logic [7:0] prv_byte  [2];
    logic       prv_last  [2];

    always #5 clk = ~clk;

    fifo_word_unpacker #(.LEN_W(LEN_W), .BIG_ENDIAN(1'b0)) u_dut_le (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .start_i(start), .len_i(len),
        .busy_o(o_busy[0]), .done_o(o_done[0]),
        .fifo_data_i(fifo_data), .fifo_valid_i(fifo_valid), .fifo_pop_o(o_pop[0]),
        .byte_o(o_byte[0]), .byte_valid_o(o_valid[0]), .byte_ready_i(ready),
        .byte_last_o(o_last[0])
    );

    fifo_word_unpacker #(.LEN_W(LEN_W), .BIG_ENDIAN(1'b1)) u_dut_be (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .start_i(start), .len_i(len),
        .busy_o(o_busy[1]), .done_o(o_done[1]),
        .fifo_data_i(fifo_data), .fifo_valid_i(fifo_valid), .fifo_pop_o(o_pop[1]),
        .byte_o(o_byte[1]), .byte_valid_o(o_valid[1]), .byte_ready_i(ready),
        .byte_last_o(o_last[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks stall stability and done timing.
    always @(negedge clk) begin
        logic [8:0] e;
        bit         have;
        bit         last_acc;
        if (mon_en) begin
            last_acc = 1'b0;
            for (int d = 0; d < 2; d++) begin
                chk(d == 0 ? "done_le" : "done_be", 32'(o_done[d]), 32'(exp_done_nx));
                if (prv_stall[d] && o_valid[d]) begin
                    chk("stall_byte", 32'(o_byte[d]), 32'(prv_byte[d]));
                    chk("stall_last", 32'(o_last[d]), 32'(prv_last[d]));
                end
                if (o_valid[d] && ready) begin
                    e = 9'd0;
                    if (d == 0) begin
                        have = (exp_le.size() != 0);
                        if (have) e = exp_le.pop_front();
                    end else begin
                        have = (exp_be.size() != 0);
                        if (have) e = exp_be.pop_front();
                    end
                    chk("byte_expected", 32'(have), 32'd1);
                    if (have) begin
                        chk(d == 0 ? "byte_le" : "byte_be", 32'(o_byte[d]), 32'(e[7:0]));
                        chk(d == 0 ? "last_le" : "last_be", 32'(o_last[d]), 32'(e[8]));
                        if (d == 0) last_acc = e[8];
                    end
                    if (d == 0) acc_cnt++;
                end
                prv_stall[d] = o_valid[d] && !ready;
                prv_byte[d]  = o_byte[d];
                prv_last[d]  = o_last[d];
            end
            exp_done_nx = !rst && !flush && (last_acc || (start && len == '0));
        end
    end

    task automatic fifo_refresh();
        fifo_valid = (fifo_q.size() != 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    endtask

    task automatic fifo_clear();
        fifo_q.delete();
        n_pops = 0;
        fifo_refresh();
    endtask

    // One clock: observe the pop at the falling edge, retire the FIFO word after the rising edge.
    task automatic tick();
        logic        pend;
        logic [31:0] w;
        @(negedge clk);
        pend = o_pop[0];
        if (o_pop[0] || o_pop[1]) chk("pop_needs_valid", 32'(fifo_valid), 32'd1);
        chk("pop_le_vs_be", 32'(o_pop[1]), 32'(o_pop[0]));
        @(posedge clk);
        #1;
        if (pend && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            n_pops++;
        end
        fifo_refresh();
    endtask

    task automatic push_seq(input logic [63:0] le, input logic [63:0] be, input int n, input bit with_last);
        logic lst;
        for (int i = 0; i < n; i++) begin
            lst = with_last && (i == n - 1);
            exp_le.push_back({lst, le[8*(n-1-i) +: 8]});
            exp_be.push_back({lst, be[8*(n-1-i) +: 8]});
        end
    endtask

    task automatic start_cmd(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic run_until_done(input int max_cyc, input bit toggle, output int ncyc);
        logic [3:0] pat;
        pat  = 4'b1001;
        ncyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            ready = toggle ? pat[i % 4] : 1'b1;
            tick();
            ncyc++;
            if (o_done[0]) begin
                ready = 1'b1;
                return;
            end
        end
        ready = 1'b1;
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_accepted(input int n, input bit toggle, input int max_cyc);
        int         base;
        logic [3:0] pat;
        pat  = 4'b1001;
        base = acc_cnt;
        for (int i = 0; i < max_cyc; i++) begin
            ready = toggle ? pat[i % 4] : 1'b1;
            tick();
            if (acc_cnt - base >= n) return;
        end
        chk("accept_timeout", 32'(acc_cnt - base), 32'(n));
    endtask

    task automatic chk_all_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_busy"},  32'(o_busy[d]),  32'd0);
            chk({nm, "_done"},  32'(o_done[d]),  32'd0);
            chk({nm, "_pop"},   32'(o_pop[d]),   32'd0);
            chk({nm, "_byte"},  32'(o_byte[d]),  32'd0);
            chk({nm, "_valid"}, 32'(o_valid[d]), 32'd0);
            chk({nm, "_last"},  32'(o_last[d]),  32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        rst = 1'b1; flush = 1'b0; start = 1'b0; len = '0; ready = 1'b1;
        for (int d = 0; d < 2; d++) begin
            prv_stall[d] = 1'b0; prv_byte[d] = 8'd0; prv_last[d] = 1'b0;
        end
        fifo_clear();
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // 1: basic 8-byte transfer, latency and no-bubble throughput
        fifo_q.push_back(32'h4433_2211);
        fifo_q.push_back(32'h8877_6655);
        fifo_refresh();
        push_seq(64'h1122334455667788, 64'h4433221188776655, 8, 1'b1);
        start_cmd(16'd8);
        chk("t1_valid_after_1", 32'(o_valid[0]), 32'd0);
        chk("t1_busy", 32'(o_busy[0]), 32'd1);
        tick();
        chk("t1_valid_after_2", 32'(o_valid[0]), 32'd1);
        run_until_done(40, 1'b0, ncyc);
        chk("t1_cycles", 32'(ncyc), 32'd8);
        tick();
        chk("t1_pops", 32'(n_pops), 32'd2);
        chk("t1_busy_end", 32'(o_busy[1]), 32'd0);

        // 2: partial word, third word must stay at the head
        fifo_clear();
        fifo_q.push_back(32'hDDCC_BBAA);
        fifo_q.push_back(32'h0000_00EE);
        fifo_q.push_back(32'h1234_5678);
        fifo_refresh();
        push_seq(64'hAABBCCDDEE, 64'hDDCCBBAA00, 5, 1'b1);
        start_cmd(16'd5);
        run_until_done(40, 1'b0, ncyc);
        tick();
        chk("t2_pops", 32'(n_pops), 32'd2);
        chk("t2_fifo_left", 32'(fifo_q.size()), 32'd1);
        chk("t2_fifo_head", fifo_data, 32'h1234_5678);

        // 3: backpressure 1,0,0,1 with starvation after the first word
        fifo_clear();
        fifo_q.push_back(32'h0403_0201);
        fifo_refresh();
        push_seq(64'h0102030405060708, 64'h0403020108070605, 8, 1'b1);
        start_cmd(16'd8);
        wait_accepted(4, 1'b1, 40);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_starve_valid", 32'(o_valid[0]), 32'd0);
            chk("t3_starve_busy", 32'(o_busy[1]), 32'd1);
            tick();
        end
        chk("t3_pops_mid", 32'(n_pops), 32'd1);
        fifo_q.push_back(32'h0807_0605);
        fifo_refresh();
        run_until_done(60, 1'b1, ncyc);
        tick();
        chk("t3_pops", 32'(n_pops), 32'd2);

        // 4: byte order check, then a zero-length command
        fifo_clear();
        fifo_q.push_back(32'hA1B2_C3D4);
        fifo_refresh();
        push_seq(64'hD4C3B2A1, 64'hA1B2C3D4, 4, 1'b1);
        start_cmd(16'd4);
        run_until_done(40, 1'b0, ncyc);
        tick();
        fifo_clear();
        fifo_q.push_back(32'h5555_5555);
        fifo_refresh();
        start_cmd(16'd0);
        chk("t4_zero_done", 32'(o_done[0]), 32'd1);
        chk("t4_zero_busy", 32'(o_busy[0]), 32'd0);
        chk("t4_zero_valid", 32'(o_valid[1]), 32'd0);
        tick();
        chk("t4_zero_done_end", 32'(o_done[1]), 32'd0);
        chk("t4_zero_pops", 32'(n_pops), 32'd0);
        chk("t4_zero_fifo", 32'(fifo_q.size()), 32'd1);

        // 5: flush after six bytes, then a fresh 4-byte command
        fifo_clear();
        fifo_q.push_back(32'h0302_0100);
        fifo_q.push_back(32'h0706_0504);
        fifo_q.push_back(32'h0B0A_0908);
        fifo_q.push_back(32'h0F0E_0D0C);
        fifo_refresh();
        push_seq(64'h000102030405, 64'h030201000706, 6, 1'b0);
        start_cmd(16'd12);
        wait_accepted(6, 1'b0, 40);
        ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ready = 1'b1;
        chk("t5_flush_valid", 32'(o_valid[0]), 32'd0);
        chk("t5_flush_busy", 32'(o_busy[1]), 32'd0);
        chk("t5_flush_pops", 32'(n_pops), 32'd2);
        tick();
        push_seq(64'h08090A0B, 64'h0B0A0908, 4, 1'b1);
        start_cmd(16'd4);
        run_until_done(40, 1'b0, ncyc);
        tick();
        chk("t5_pops", 32'(n_pops), 32'd3);
        chk("t5_fifo_head", fifo_data, 32'h0F0E_0D0C);

        // 6: reset mid-transfer with a command held across reset
        fifo_clear();
        fifo_q.push_back(32'h1122_3344);
        fifo_q.push_back(32'h5566_7788);
        fifo_refresh();
        push_seq(64'h4433, 64'h1122, 2, 1'b0);
        start_cmd(16'd8);
        wait_accepted(2, 1'b0, 40);
        ready = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        len   = 16'd4;
        tick();
        chk_all_zero("t6_reset");
        tick();
        tick();
        chk("t6_held_busy", 32'(o_busy[0]), 32'd0);
        chk("t6_pops", 32'(n_pops), 32'd1);
        fifo_clear();
        fifo_q.push_back(32'hCAFE_F00D);
        fifo_refresh();
        push_seq(64'h0DF0FECA, 64'hCAFEF00D, 4, 1'b1);
        rst   = 1'b0;
        ready = 1'b1;
        tick();
        start = 1'b0;
        len   = '0;
        chk("t6_restart_busy", 32'(o_busy[1]), 32'd1);
        run_until_done(40, 1'b0, ncyc);
        tick();
        chk("t6_final_pops", 32'(n_pops), 32'd1);

        chk("sb_le_empty", 32'(exp_le.size()), 32'd0);
        chk("sb_be_empty", 32'(exp_be.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
